// File: rtl/lsu_mem_initiator_if.sv
// Purpose: request/response handshake and data-memory bus of the load/store
//          initiator, bundled so core side and initiator share one connection.
// Signals:
//   req_valid/req_ready    request handshake (ready = initiator idle)
//   req_store, req_funct3  access kind and RISC-V size/sign encoding
//   req_addr, req_wdata    byte address and store data
//   resp_valid             one-cycle response pulse
//   resp_rdata, resp_err   extended load data / rejected-request flag
//   mem_A, mem_WD, mem_WE  word index, write data and write enable to memory
//   mem_RD                 combinational read data from memory
// Modports: master = core/memory side, slave = initiator.
interface lsu_mem_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_WE;
    logic [31:0] mem_RD;

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_RD,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_A, mem_WD, mem_WE
    );

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_RD,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_A, mem_WD, mem_WE
    );
endinterface

// File: rtl/lsu_mem_initiator.sv
// Purpose: converts one byte-addressed RISC-V load/store per handshake into
//          word-indexed data-memory accesses. Sub-word stores are done as
//          read-modify-write; loads are aligned and sign/zero-extended.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-low reset
//   lsu  lsu_mem_initiator_if.slave: request, response and memory bus
// Memory outputs (mem_A/mem_WD/mem_WE) are state decodes; mem_WE is also
// gated by rst so a reset landing on a WRITE cycle never touches memory.
module lsu_mem_initiator #(
    parameter int unsigned ADDR_LIMIT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    lsu_mem_initiator_if.slave   lsu
);

    localparam int unsigned AW = $clog2(ADDR_LIMIT);
    localparam int unsigned DW = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_WRITE,
        S_ERR,
        S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   merge_q, merge_d;
    logic            resp_valid_q, resp_valid_d;
    logic            resp_err_q, resp_err_d;
    logic [DW-1:0]   resp_rdata_q, resp_rdata_d;

    logic            req_err_c;
    logic [4:0]      shamt_c;
    logic [DW-1:0]   shifted_c;
    logic [DW-1:0]   load_ext_c;
    logic [DW-1:0]   mask_c;
    logic [DW-1:0]   merged_c;
    logic [DW-1:0]   mem_a_c;
    logic [DW-1:0]   mem_wd_c;
    logic            mem_we_c;

    // Request classification: bad encoding, misalignment or out-of-range.
    always_comb begin
        logic f3_ok;
        logic misalign;
        logic range_bad;
        if (lsu.req_store) begin
            f3_ok = (lsu.req_funct3 == 3'b000) || (lsu.req_funct3 == 3'b001) ||
                    (lsu.req_funct3 == 3'b010);
        end else begin
            f3_ok = (lsu.req_funct3 == 3'b000) || (lsu.req_funct3 == 3'b001) ||
                    (lsu.req_funct3 == 3'b010) || (lsu.req_funct3 == 3'b100) ||
                    (lsu.req_funct3 == 3'b101);
        end
        misalign  = ((lsu.req_funct3[1:0] == 2'b01) && lsu.req_addr[0]) ||
                    ((lsu.req_funct3[1:0] == 2'b10) && (lsu.req_addr[1:0] != 2'b00));
        range_bad = (lsu.req_addr >= DW'(ADDR_LIMIT));
        req_err_c = !f3_ok || misalign || range_bad;
    end

    // Little-endian lane shift shared by load extraction and store merge.
    always_comb begin
        shamt_c   = {addr_q[1:0], 3'b000};
        shifted_c = lsu.mem_RD >> shamt_c;
        case (funct3_q)
            3'b000:  load_ext_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
            3'b001:  load_ext_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
            3'b100:  load_ext_c = {24'h0, shifted_c[7:0]};
            3'b101:  load_ext_c = {16'h0, shifted_c[15:0]};
            default: load_ext_c = shifted_c;
        endcase
        mask_c   = (funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << shamt_c;
        merged_c = (merge_q & ~mask_c) | ((wdata_q << shamt_c) & mask_c);
    end

    // Next-state and memory-bus decode.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        wdata_d      = wdata_q;
        merge_d      = merge_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        mem_a_c      = '0;
        mem_wd_c     = '0;
        mem_we_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (lsu.req_valid) begin
                    addr_d   = lsu.req_addr[AW-1:0];
                    funct3_d = lsu.req_funct3;
                    wdata_d  = lsu.req_wdata;
                    if (req_err_c) begin
                        state_d = S_ERR;
                    end else if (!lsu.req_store) begin
                        state_d = S_LOAD;
                    end else if (lsu.req_funct3 == 3'b010) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_LOAD: begin
                mem_a_c      = DW'(addr_q[AW-1:2]);
                resp_rdata_d = load_ext_c;
                resp_err_d   = 1'b0;
                state_d      = S_RESP;
            end
            S_READ: begin
                mem_a_c = DW'(addr_q[AW-1:2]);
                merge_d = lsu.mem_RD;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                mem_a_c      = DW'(addr_q[AW-1:2]);
                mem_wd_c     = funct3_q[1] ? wdata_q : merged_c;
                mem_we_c     = rst;
                resp_rdata_d = '0;
                resp_err_d   = 1'b0;
                state_d      = S_RESP;
            end
            S_ERR: begin
                resp_rdata_d = '0;
                resp_err_d   = 1'b1;
                state_d      = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        resp_valid_d = (state_d == S_RESP);
    end

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            funct3_q     <= '0;
            wdata_q      <= '0;
            merge_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            wdata_q      <= wdata_d;
            merge_q      <= merge_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign lsu.req_ready  = (state_q == S_IDLE);
    assign lsu.resp_valid = resp_valid_q;
    assign lsu.resp_err   = resp_err_q;
    assign lsu.resp_rdata = resp_rdata_q;
    assign lsu.mem_A      = mem_a_c;
    assign lsu.mem_WD     = mem_wd_c;
    assign lsu.mem_WE     = mem_we_c;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Purpose: self-checking bench for lsu_mem_initiator with a 256-word memory
//          model, a reference memory image and a response scoreboard.
module tb_lsu_mem_initiator;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic clk;
    logic rst;
    lsu_mem_initiator_if bus();

    lsu_mem_initiator #(.ADDR_LIMIT(1024)) dut (
        .clk (clk),
        .rst (rst),
        .lsu (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem      [256];
    logic [31:0] ref_mem  [256];
    logic [31:0] init_img [256];
    logic        mem_init;

    int          cyc;
    int          we_count;
    int          last_we_cyc;
    logic [31:0] last_we_a;
    logic [31:0] last_we_wd;

    int          n_tests;
    int          n_fail;
    int          resp_cnt;
    logic [31:0] last_rdata;
    logic        last_err;
    exp_t        sb[$];

    assign bus.mem_RD = mem[bus.mem_A[7:0]];

    // Data memory: image load during reset, otherwise clocked writes.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_img[i];
        end else if (bus.mem_WE) begin
            mem[bus.mem_A[7:0]] <= bus.mem_WD;
        end
    end

    // Cycle counter and write-strobe recorder.
    always @(posedge clk) begin
        if (bus.mem_WE) begin
            we_count    <= we_count + 1;
            last_we_cyc <= cyc;
            last_we_a   <= bus.mem_A;
            last_we_wd  <= bus.mem_WD;
        end
        cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Response monitor: pops the scoreboard on every response pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) begin
                resp_cnt++;
                last_rdata = bus.resp_rdata;
                last_err   = bus.resp_err;
                if (sb.size() == 0) begin
                    check_eq("spurious_resp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("resp_rdata", bus.resp_rdata, e.rdata);
                    check_eq("resp_err", 32'(bus.resp_err), 32'(e.err));
                    check_eq("resp_cycle", 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    // Reference model: expected response, timing and memory update.
    task automatic predict(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int n, output exp_t e);
        logic        bad;
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        int          idx;
        int          off;
        bad = (a >= 32'd1024);
        if (st) begin
            if (f3 > 3'd2) bad = 1'b1;
        end else if (f3 == 3'd3 || f3 > 3'd5) begin
            bad = 1'b1;
        end
        if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) bad = 1'b1;
        if (f3 == 3'd2 && a[1:0] != 2'b00) bad = 1'b1;
        idx = int'(a[9:2]);
        off = int'(a[1:0]);
        w   = ref_mem[idx];
        b   = w[8*off +: 8];
        h   = w[16*(off/2) +: 16];
        e.rdata = 32'h0;
        e.err   = bad;
        e.due   = n + 2;
        if (!bad && !st) begin
            case (f3)
                3'd0:    e.rdata = {{24{b[7]}}, b};
                3'd1:    e.rdata = {{16{h[15]}}, h};
                3'd4:    e.rdata = {24'h0, b};
                3'd5:    e.rdata = {16'h0, h};
                default: e.rdata = w;
            endcase
        end else if (!bad) begin
            case (f3)
                3'd0:    w[8*off +: 8] = wd[7:0];
                3'd1:    w[16*(off/2) +: 16] = wd[15:0];
                default: w = wd;
            endcase
            ref_mem[idx] = w;
            if (f3 != 3'd2) e.due = n + 3;
        end
    endtask

    // Present a request (called at a negedge); returns at the negedge after
    // acceptance with req_valid still high. acc = cycle N of acceptance.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit track, output int acc);
        exp_t e;
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        acc = -1;
        for (int n = 0; n < 20; n++) begin
            if (bus.req_ready === 1'b1) begin
                acc = cyc;
                if (track) begin
                    predict(st, f3, a, wd, acc, e);
                    sb.push_back(e);
                end
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) check_eq("accept_timeout", 32'd1, 32'd0);
        else @(negedge clk);
    endtask

    task automatic drop();
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check_eq("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc;
        int          we0;
        int          r0;
        logic [31:0] wsave;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [2:0]  f3_tbl [8];

        n_tests = 0; n_fail = 0; resp_cnt = 0;
        cyc = 0; we_count = 0; last_we_cyc = -1; last_we_a = '0; last_we_wd = '0;
        last_rdata = '0; last_err = 1'b0;
        f3_tbl = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};

        for (int i = 0; i < 256; i++) init_img[i] = $urandom;
        init_img[1] = 32'h8899_AABB;
        init_img[2] = 32'h1122_3344;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_img[i];

        rst = 1'b0; mem_init = 1'b1;
        bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = '0; bus.req_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1; mem_init = 1'b0;
        @(negedge clk);

        check_eq("rst_ready", 32'(bus.req_ready), 32'd1);
        check_eq("rst_valid", 32'(bus.resp_valid), 32'd0);
        check_eq("rst_err", 32'(bus.resp_err), 32'd0);
        check_eq("rst_rdata", bus.resp_rdata, 32'd0);
        check_eq("rst_we", 32'(bus.mem_WE), 32'd0);
        check_eq("rst_mem_a", bus.mem_A, 32'd0);

        // Loads from word 1 = 0x8899AABB.
        issue(1'b0, 3'd0, 32'h6, 32'h0, 1'b1, acc); drop(); drain();
        check_eq("lb_0x6", last_rdata, 32'hFFFF_FF99);
        issue(1'b0, 3'd4, 32'h6, 32'h0, 1'b1, acc); drop(); drain();
        check_eq("lbu_0x6", last_rdata, 32'h0000_0099);
        issue(1'b0, 3'd5, 32'h6, 32'h0, 1'b1, acc); drop(); drain();
        check_eq("lhu_0x6", last_rdata, 32'h0000_8899);
        issue(1'b0, 3'd1, 32'h4, 32'h0, 1'b1, acc); drop(); drain();
        check_eq("lh_0x4", last_rdata, 32'hFFFF_AABB);

        // SB into word 2 as read-modify-write.
        we0 = we_count;
        issue(1'b1, 3'd0, 32'h9, 32'hDEAD_BEEF, 1'b1, acc); drop(); drain();
        check_eq("sb_we_count", 32'(we_count - we0), 32'd1);
        check_eq("sb_we_cycle", 32'(last_we_cyc), 32'(acc + 2));
        check_eq("sb_mem_a", last_we_a, 32'd2);
        check_eq("sb_mem_wd", last_we_wd, 32'h1122_EF44);
        check_eq("sb_err", 32'(last_err), 32'd0);
        check_eq("sb_mem2", mem[2], 32'h1122_EF44);

        // SW then LW at 0x0C.
        we0 = we_count;
        issue(1'b1, 3'd2, 32'hC, 32'hCAFE_F00D, 1'b1, acc); drop(); drain();
        check_eq("sw_we_count", 32'(we_count - we0), 32'd1);
        check_eq("sw_we_cycle", 32'(last_we_cyc), 32'(acc + 1));
        check_eq("sw_mem_a", last_we_a, 32'd3);
        check_eq("sw_mem_wd", last_we_wd, 32'hCAFE_F00D);
        issue(1'b0, 3'd2, 32'hC, 32'h0, 1'b1, acc); drop(); drain();
        check_eq("lw_0xc", last_rdata, 32'hCAFE_F00D);

        // Rejected requests: misaligned LW/SH, out of range, bad funct3.
        we0 = we_count;
        issue(1'b0, 3'd2, 32'h5, 32'h0, 1'b1, acc); drop(); drain();
        check_eq("err_lw5", 32'(last_err), 32'd1);
        check_eq("err_lw5_rdata", last_rdata, 32'd0);
        issue(1'b1, 3'd1, 32'h3, 32'h1234_5678, 1'b1, acc); drop(); drain();
        check_eq("err_sh3", 32'(last_err), 32'd1);
        issue(1'b0, 3'd2, 32'h400, 32'h0, 1'b1, acc); drop(); drain();
        check_eq("err_lw400", 32'(last_err), 32'd1);
        issue(1'b0, 3'd3, 32'h8, 32'h0, 1'b1, acc); drop(); drain();
        check_eq("err_f3_011", 32'(last_err), 32'd1);
        check_eq("err_f3_rdata", last_rdata, 32'd0);
        check_eq("err_no_we", 32'(we_count - we0), 32'd0);

        // Reset asserted during the WRITE cycle of an SH to word 5.
        we0   = we_count;
        r0    = resp_cnt;
        wsave = mem[5];
        issue(1'b1, 3'd1, 32'h14, 32'hAAAA_5555, 1'b0, acc); drop();
        @(negedge clk);
        rst = 1'b0;
        #1 check_eq("rstw_we_gated", 32'(bus.mem_WE), 32'd0);
        @(negedge clk);
        check_eq("rstw_no_resp", 32'(bus.resp_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rstw_ready", 32'(bus.req_ready), 32'd1);
        check_eq("rstw_mem5", mem[5], wsave);
        check_eq("rstw_we_count", 32'(we_count - we0), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("rstw_resp_cnt", 32'(resp_cnt - r0), 32'd0);

        // req_valid held high with alternating LW/SW.
        r0 = resp_cnt;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) issue(1'b0, 3'd2, 32'(64 + 4*i), 32'h0, 1'b1, acc);
            else            issue(1'b1, 3'd2, 32'(64 + 4*(i-1)), 32'(32'h5A00_0000 + i), 1'b1, acc);
        end
        drop(); drain();
        check_eq("b2b_resp_cnt", 32'(resp_cnt - r0), 32'd8);

        // Randomised mix, including bad encodings and out-of-range addresses.
        for (int i = 0; i < 40; i++) begin
            st = 1'($urandom_range(0, 1));
            f3 = f3_tbl[$urandom_range(0, 7)];
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            if ($urandom_range(0, 9) == 0) a = 32'(1024 + $urandom_range(0, 4095));
            issue(st, f3, a, $urandom, 1'b1, acc);
            drop();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        for (int i = 16; i < 64; i++) check_eq("final_mem", mem[i], ref_mem[i]);

        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
